plot_arbiter: RTL and testbench
===============================

# plot_arbiter

Sits between the screen drawers (game board drawer, win-banner drawer) and the single `vga_adapter` instance on the 160x120, 3-bit-colour display. Owns the adapter's x/y/colour/plot port. Performs a full-screen clear on request, then grants the port to one of two drawer clients by round-robin request/grant handshake. Lets each drawer FSM assume exclusive access to the framebuffer.

## Interface
Parameters:
- `XMAX`, 159, last x coordinate of the clear raster
- `YMAX`, 119, last y coordinate of the clear raster
- `CLEAR_COLOUR`, 3'b000, colour written during clear

Ports:
- `fastclock`  in  1  system clock (CLOCK_50)
- `resetn`  in  1  reset, synchronous, active-low
- `clear_req`  in  1  request full-screen clear; level, sampled in IDLE only
- `clear_busy`  out  1  high while in CLEAR
- `clear_done`  out  1  one-cycle pulse on CLEAR completion
- `c0_req`, `c1_req`  in  1 each  client wants the port; held high for the whole drawing job
- `c0_grant`, `c1_grant`  out  1 each  client owns the port
- `c0_x`/`c1_x`  in  8; `c0_y`/`c1_y`  in  7; `c0_colour`/`c1_colour`  in  3; `c0_plot`/`c1_plot`  in  1  client pixel write
- `x`  out  8; `y`  out  7; `colour`  out  3; `plot`  out  1  to vga_adapter

## Operation
- States: IDLE, CLEAR, GRANT0, GRANT1. Encoding 2 bits.
- IDLE priority:
  - `clear_req` or `clear_pend` → CLEAR.
  - Otherwise round-robin on `c0_req`/`c1_req` using `last`: if both request, grant the client not equal to `last`; a single requester is granted directly.
  - No request → stay in IDLE.
- CLEAR: raster counter starts at (0,0). Every cycle: plot=1, colour=CLEAR_COLOUR, x increments. At x==XMAX, x→0 and y increments. After pixel (XMAX,YMAX) → IDLE with `clear_done`=1 for that one IDLE cycle. Total 19200 plot cycles.
- GRANTn: grant_n=1. Outputs x/y/colour/plot pass through combinationally from client n (zero latency). Stays while cn_req=1. On cn_req=0 → IDLE, `last`←n.
- A `clear_req` that arrives during GRANTn sets `clear_pend`. It is serviced at the next IDLE ahead of clients. `clear_pend` clears on entry to CLEAR.
- Non-granted client's plot is ignored. In IDLE, plot=0 and x/y/colour=0.
- Only one grant is ever high. Grant is never high in CLEAR or IDLE.
- Reset values: state IDLE, raster (0,0), `last`=1 (c0 wins first tie), `clear_pend`=0. All outputs 0: grants, clear_busy, clear_done, x, y, colour, plot.

## Timing
- `clear_req` high at IDLE edge k:
  - state CLEAR from k+1.
  - First plot (0,0) in cycle k+1; last plot (159,119) in cycle k+19200.
  - `clear_done` and state IDLE in cycle k+19201.
- Request high at IDLE edge e: grant high from cycle e+1. Client plots are valid from the first cycle grant is seen high.
- Request low at GRANT edge f: grant low from f+1 (IDLE). The earliest next grant is at f+2. IDLE always lasts at least one cycle between owners.
- Simultaneous `clear_req` and client req in IDLE: clear wins; the client waits until after `clear_done`.
- Client dropping req and a clear request arriving on the same edge: → IDLE (pend set), then CLEAR next edge.
- Reset asserted mid-CLEAR or mid-GRANT: on that edge, return to IDLE, zero the raster, and drop `clear_pend` and all grants. No `clear_done`.
- Raster widths: x 8-bit, y 7-bit. No wrap beyond XMAX/YMAX.

## Structure
- Shared package `vga_pkg`: screen constants (160, 120, XMAX, YMAX), coordinate widths (8/7), colour constants (BLACK 3'b000, YELLOW 3'b110), state encoding localparams.
- Sub-module `raster_counter`:
  - Inputs: clear, enable.
  - Outputs: x, y, last.
  - Reused by the drawers.
- Arbiter FSM and output mux live in `plot_arbiter`.

## Test plan
- Reset, then `clear_req` pulse → exactly 19200 plot cycles with colour 0, first (0,0), last (159,119), `clear_done` one cycle at +19201, no grants.
- c0_req only; c0 drives (10,7,3'b110,plot=1) → x=10, y=7, colour=6, plot=1 in the same cycle, starting one cycle after req. Drop req → grant low next cycle.
- c0_req and c1_req both held after reset → c0 granted first. c0 releases → one IDLE cycle → c1 granted. c0 re-requests while c1 is granted → c0 after c1 releases.
- c1 granted, `clear_req` pulsed mid-job → no clear until c1 releases. Then CLEAR starts with c0_req also high; c0 is granted only after `clear_done`.
- Ungranted c1 plots (5,5) while c0 owns the port with plot=0 → adapter plot stays 0.
- resetn low at raster (80,60) → next cycle IDLE, plot=0, `clear_busy`=0, no `clear_done`. A new `clear_req` restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared display constants for the 160x120, 3-bit-colour VGA framebuffer.
// Used by the plot arbiter, the raster counter and the screen drawers.
//   - screen geometry and last-coordinate values
//   - coordinate and colour widths
//   - named colours
//   - arbiter state encoding
package vga_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [X_W-1:0] SCREEN_XMAX = 8'd159;
    localparam logic [Y_W-1:0] SCREEN_YMAX = 7'd119;

    localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
    localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;

    // Arbiter FSM encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StClear  = 2'd1;
    localparam logic [1:0] StGrant0 = 2'd2;
    localparam logic [1:0] StGrant1 = 2'd3;

    // One pixel write towards the adapter
    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
        logic                plot;
    } pixel_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major raster scan counter over (0,0)..(XMAX,YMAX).
// Ports:
//   fastclock - clock
//   resetn    - synchronous active-low reset, zeroes the raster
//   clear     - return to (0,0); wins over enable
//   enable    - advance one pixel; x runs fastest
//   x, y      - current raster position
//   last      - high while the position is (XMAX,YMAX)
module raster_counter
    import vga_pkg::*;
#(
    parameter logic [X_W-1:0] XMAX = SCREEN_XMAX,
    parameter logic [Y_W-1:0] YMAX = SCREEN_YMAX
) (
    input  logic           fastclock,
    input  logic           resetn,
    input  logic           clear,
    input  logic           enable,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end, y_end;

    assign x_end = (x_q == XMAX);
    assign y_end = (y_q == YMAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (enable) begin
            if (x_end) begin
                x_d = '0;
                // After the final pixel the scan returns to the origin
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge fastclock) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_end && y_end;

endmodule

// File: rtl/plot_arbiter.sv
// Owns the single vga_adapter pixel port. Runs a full-screen clear on
// request, otherwise hands the port to one of two drawer clients by
// round-robin request/grant, so each drawer can assume exclusive access.
// Ports:
//   fastclock, resetn       - clock, synchronous active-low reset
//   clear_req               - level request for a full-screen clear
//   clear_busy, clear_done  - clear in progress / one-cycle completion pulse
//   c0_*/c1_*               - client request, grant and pixel write
//   x, y, colour, plot      - pixel write to the vga_adapter
module plot_arbiter
    import vga_pkg::*;
#(
    parameter logic [X_W-1:0]      XMAX         = SCREEN_XMAX,
    parameter logic [Y_W-1:0]      YMAX         = SCREEN_YMAX,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = BLACK
) (
    input  logic                fastclock,
    input  logic                resetn,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                clear_done,
    input  logic                c0_req,
    input  logic                c1_req,
    output logic                c0_grant,
    output logic                c1_grant,
    input  logic [X_W-1:0]      c0_x,
    input  logic [Y_W-1:0]      c0_y,
    input  logic [COLOUR_W-1:0] c0_colour,
    input  logic                c0_plot,
    input  logic [X_W-1:0]      c1_x,
    input  logic [Y_W-1:0]      c1_y,
    input  logic [COLOUR_W-1:0] c1_colour,
    input  logic                c1_plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;        // client that most recently released
    logic       clear_pend_q, clear_pend_d;
    logic       clear_done_q, clear_done_d;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_last;
    logic           in_clear;

    pixel_t pix;

    assign in_clear = (state_q == StClear);

    // Raster is held at the origin whenever no clear is running
    raster_counter #(
        .XMAX (XMAX),
        .YMAX (YMAX)
    ) u_raster (
        .fastclock (fastclock),
        .resetn    (resetn),
        .clear     (!in_clear),
        .enable    (in_clear),
        .x         (r_x),
        .y         (r_y),
        .last      (r_last)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        clear_pend_d = clear_pend_q;
        clear_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (clear_req || clear_pend_q) begin
                    state_d      = StClear;
                    clear_pend_d = 1'b0;
                end else if (c0_req && c1_req) begin
                    state_d = last_q ? StGrant0 : StGrant1;
                end else if (c0_req) begin
                    state_d = StGrant0;
                end else if (c1_req) begin
                    state_d = StGrant1;
                end
            end
            StClear: begin
                if (r_last) begin
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end
            end
            StGrant0: begin
                // A clear during a job waits for the owner to finish
                clear_pend_d = clear_pend_q | clear_req;
                if (!c0_req) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end
            StGrant1: begin
                clear_pend_d = clear_pend_q | clear_req;
                if (!c1_req) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge fastclock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            clear_pend_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            clear_pend_q <= clear_pend_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Zero-latency pass-through from the owner; nothing else reaches the port
    always_comb begin
        pix = '0;
        case (state_q)
            StClear: begin
                pix.x      = r_x;
                pix.y      = r_y;
                pix.colour = CLEAR_COLOUR;
                pix.plot   = 1'b1;
            end
            StGrant0: begin
                pix.x      = c0_x;
                pix.y      = c0_y;
                pix.colour = c0_colour;
                pix.plot   = c0_plot;
            end
            StGrant1: begin
                pix.x      = c1_x;
                pix.y      = c1_y;
                pix.colour = c1_colour;
                pix.plot   = c1_plot;
            end
            default: begin
                pix = '0;
            end
        endcase
    end

    assign x          = pix.x;
    assign y          = pix.y;
    assign colour     = pix.colour;
    assign plot       = pix.plot;
    assign c0_grant   = (state_q == StGrant0);
    assign c1_grant   = (state_q == StGrant1);
    assign clear_busy = in_clear;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;

    logic       fastclock = 1'b0;
    logic       resetn;
    logic       clear_req;
    logic       clear_busy, clear_done;
    logic       c0_req, c1_req, c0_grant, c1_grant;
    logic [7:0] c0_x, c1_x, x;
    logic [6:0] c0_y, c1_y, y;
    logic [2:0] c0_colour, c1_colour, colour;
    logic       c0_plot, c1_plot, plot;

    int total = 0;
    int bad   = 0;

    always #5 fastclock = ~fastclock;

    plot_arbiter dut (
        .fastclock  (fastclock),
        .resetn     (resetn),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .c0_req     (c0_req),
        .c1_req     (c1_req),
        .c0_grant   (c0_grant),
        .c1_grant   (c1_grant),
        .c0_x       (c0_x),
        .c0_y       (c0_y),
        .c0_colour  (c0_colour),
        .c0_plot    (c0_plot),
        .c1_x       (c1_x),
        .c1_y       (c1_y),
        .c1_colour  (c1_colour),
        .c1_plot    (c1_plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    task automatic tick();
        @(posedge fastclock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered in the first CLEAR cycle; leaves one cycle after clear_done.
    task automatic run_clear(input string tag);
        int errs = 0;
        int ex;
        int ey;
        for (int i = 0; i < 19200; i++) begin
            ex = i % 160;
            ey = i / 160;
            if (x !== ex[7:0] || y !== ey[6:0] || plot !== 1'b1 || colour !== 3'b000 ||
                clear_busy !== 1'b1 || clear_done !== 1'b0 ||
                c0_grant !== 1'b0 || c1_grant !== 1'b0)
                errs++;
            if (i == 0) begin
                chk({tag, "_first_x"}, 32'(x), 32'd0);
                chk({tag, "_first_y"}, 32'(y), 32'd0);
            end
            if (i == 19199) begin
                chk({tag, "_last_x"}, 32'(x), 32'd159);
                chk({tag, "_last_y"}, 32'(y), 32'd119);
            end
            tick();
        end
        chk({tag, "_bad_cycles"}, 32'(errs), 32'd0);
        chk({tag, "_done"}, 32'(clear_done), 32'd1);
        chk({tag, "_busy_off"}, 32'(clear_busy), 32'd0);
        chk({tag, "_plot_off"}, 32'(plot), 32'd0);
        chk({tag, "_g0_off"}, 32'(c0_grant), 32'd0);
        chk({tag, "_g1_off"}, 32'(c1_grant), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(clear_done), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; clear_req = 1'b0;
        c0_req = 1'b0; c0_x = '0; c0_y = '0; c0_colour = '0; c0_plot = 1'b0;
        c1_req = 1'b0; c1_x = '0; c1_y = '0; c1_colour = '0; c1_plot = 1'b0;
        tick();
        tick();
        chk("rst_g0", 32'(c0_grant), 32'd0);
        chk("rst_g1", 32'(c1_grant), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        resetn = 1'b1;
        tick();

        // Full clear from reset
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run_clear("clr1");

        // Single client c0, combinational pass-through
        c0_req = 1'b1; c0_x = 8'd10; c0_y = 7'd7; c0_colour = 3'b110; c0_plot = 1'b1;
        #1;
        chk("t2_idle_g0", 32'(c0_grant), 32'd0);
        chk("t2_idle_plot", 32'(plot), 32'd0);
        tick();
        chk("t2_g0", 32'(c0_grant), 32'd1);
        chk("t2_g1", 32'(c1_grant), 32'd0);
        chk("t2_x", 32'(x), 32'd10);
        chk("t2_y", 32'(y), 32'd7);
        chk("t2_colour", 32'(colour), 32'd6);
        chk("t2_plot", 32'(plot), 32'd1);
        c0_x = 8'd11;
        #1;
        chk("t2_x_comb", 32'(x), 32'd11);
        c0_req = 1'b0;
        #1;
        chk("t2_g0_hold", 32'(c0_grant), 32'd1);
        tick();
        chk("t2_g0_drop", 32'(c0_grant), 32'd0);
        chk("t2_idle_plot2", 32'(plot), 32'd0);
        chk("t2_idle_x", 32'(x), 32'd0);

        // Round-robin from a fresh reset: c0 wins the first tie
        c0_plot = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        c0_req = 1'b1; c1_req = 1'b1;
        tick();
        chk("t3_tie_g0", 32'(c0_grant), 32'd1);
        chk("t3_tie_g1", 32'(c1_grant), 32'd0);
        c0_req = 1'b0;
        tick();
        chk("t3_gap_g0", 32'(c0_grant), 32'd0);
        chk("t3_gap_g1", 32'(c1_grant), 32'd0);
        tick();
        chk("t3_g1", 32'(c1_grant), 32'd1);
        c1_x = 8'd20; c1_y = 7'd30; c1_colour = 3'd5; c1_plot = 1'b1;
        c0_x = 8'd99; c0_plot = 1'b1; c0_req = 1'b1;
        #1;
        chk("t3_c1_x", 32'(x), 32'd20);
        chk("t3_c1_y", 32'(y), 32'd30);
        chk("t3_c1_colour", 32'(colour), 32'd5);
        tick();
        chk("t3_g1_keep", 32'(c1_grant), 32'd1);
        chk("t3_g0_wait", 32'(c0_grant), 32'd0);
        c1_req = 1'b0;
        tick();
        chk("t3_gap2_g0", 32'(c0_grant), 32'd0);
        chk("t3_gap2_g1", 32'(c1_grant), 32'd0);
        tick();
        chk("t3_g0_again", 32'(c0_grant), 32'd1);

        // Ungranted client plots are ignored
        c0_plot = 1'b0; c1_x = 8'd5; c1_y = 7'd5; c1_plot = 1'b1;
        #1;
        chk("t5_plot", 32'(plot), 32'd0);
        chk("t5_x", 32'(x), 32'd99);

        // c1 owns the port, clear arrives mid-job and is deferred
        c0_req = 1'b0; c1_req = 1'b1;
        tick();
        chk("t4_idle_g1", 32'(c1_grant), 32'd0);
        tick();
        chk("t4_g1", 32'(c1_grant), 32'd1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("t4_g1_during", 32'(c1_grant), 32'd1);
        chk("t4_busy_defer", 32'(clear_busy), 32'd0);
        c0_req = 1'b1; c1_req = 1'b0;
        tick();
        chk("t4_idle_busy", 32'(clear_busy), 32'd0);
        chk("t4_idle_g0", 32'(c0_grant), 32'd0);
        tick();
        run_clear("clr2");
        chk("t4_g0_after", 32'(c0_grant), 32'd1);

        // Release and clear on the same edge
        c0_req = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("t6_idle_busy", 32'(clear_busy), 32'd0);
        chk("t6_idle_g0", 32'(c0_grant), 32'd0);
        chk("t6_idle_plot", 32'(plot), 32'd0);
        tick();
        chk("t6_busy", 32'(clear_busy), 32'd1);
        chk("t6_x0", 32'(x), 32'd0);

        // Reset mid-clear at (80,60)
        repeat (9680) tick();
        chk("t7_x80", 32'(x), 32'd80);
        chk("t7_y60", 32'(y), 32'd60);
        resetn = 1'b0;
        tick();
        chk("t7_rst_busy", 32'(clear_busy), 32'd0);
        chk("t7_rst_plot", 32'(plot), 32'd0);
        chk("t7_rst_done", 32'(clear_done), 32'd0);
        resetn = 1'b1;
        tick();
        chk("t7_no_done", 32'(clear_done), 32'd0);
        chk("t7_idle_busy", 32'(clear_busy), 32'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("t7_restart_busy", 32'(clear_busy), 32'd1);
        chk("t7_restart_x", 32'(x), 32'd0);
        chk("t7_restart_y", 32'(y), 32'd0);
        chk("t7_restart_plot", 32'(plot), 32'd1);
        tick();
        chk("t7_step_x", 32'(x), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
